// File: rtl/role_ctrl_pkg.sv
// Shared constants, types and helpers for the role control register file.
// Response codes, register map indices, CTRL bit positions, strobe expansion.
package role_ctrl_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int REG_CTRL       = 0;
    localparam int REG_IRQ_STATUS = 1;
    localparam int REG_IRQ_ENABLE = 2;

    localparam int CTRL_SOFT_RST_BIT  = 0;
    localparam int CTRL_DOORBELL_BIT  = 1;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_HAVE_AW,
        WR_HAVE_W,
        WR_HAVE_BOTH
    } wr_state_e;

    // Expands up to 8 byte strobes into a 64-bit bit mask.
    function automatic logic [63:0] strb_to_mask(input logic [7:0] strb);
        logic [63:0] m;
        m = '0;
        for (int b = 0; b < 8; b++) begin
            m[b*8 +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/role_ctrl_axil_if.sv
// AXI4-Lite slave handshake engine: latches AW/W independently, commits once
// both are held and B is idle, and registers read data. Emits wr_en/idx/data/mask
// and rd_en/idx; register decode lives in the parent.
module role_ctrl_axil_if
    import role_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    localparam int STRB_W    = DATA_WIDTH / 8,
    localparam int OFF_W     = $clog2(STRB_W),
    localparam int IDX_W     = ADDR_WIDTH - OFF_W
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  s_axi_ctrl_awvalid,
    output logic                  s_axi_ctrl_awready,
    input  logic [ADDR_WIDTH-1:0] s_axi_ctrl_awaddr,
    input  logic [2:0]            s_axi_ctrl_awprot,
    input  logic                  s_axi_ctrl_wvalid,
    output logic                  s_axi_ctrl_wready,
    input  logic [DATA_WIDTH-1:0] s_axi_ctrl_wdata,
    input  logic [STRB_W-1:0]     s_axi_ctrl_wstrb,
    output logic                  s_axi_ctrl_bvalid,
    input  logic                  s_axi_ctrl_bready,
    output logic [1:0]            s_axi_ctrl_bresp,
    input  logic                  s_axi_ctrl_arvalid,
    output logic                  s_axi_ctrl_arready,
    input  logic [ADDR_WIDTH-1:0] s_axi_ctrl_araddr,
    input  logic [2:0]            s_axi_ctrl_arprot,
    output logic                  s_axi_ctrl_rvalid,
    input  logic                  s_axi_ctrl_rready,
    output logic [DATA_WIDTH-1:0] s_axi_ctrl_rdata,
    output logic [1:0]            s_axi_ctrl_rresp,
    output logic                  wr_en,
    output logic [IDX_W-1:0]      wr_idx,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] wr_mask,
    output logic                  rd_en,
    output logic [IDX_W-1:0]      rd_idx,
    input  logic [DATA_WIDTH-1:0] rd_data
);

    localparam logic [IDX_W:0] NREGS = (IDX_W+1)'(NUM_REGS);

    wr_state_e             wr_state_q, wr_state_d;
    logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0]     w_strb_q, w_strb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    logic aw_hs;
    logic w_hs;
    logic commit;
    logic wr_ok;
    logic rd_ok;
    logic unused_bits;

    assign unused_bits = ^{s_axi_ctrl_awprot, s_axi_ctrl_arprot,
                           s_axi_ctrl_awaddr[OFF_W-1:0],
                           s_axi_ctrl_araddr[OFF_W-1:0]};

    assign s_axi_ctrl_awready = (wr_state_q == WR_IDLE) ||
                                (wr_state_q == WR_HAVE_W);
    assign s_axi_ctrl_wready  = (wr_state_q == WR_IDLE) ||
                                (wr_state_q == WR_HAVE_AW);
    assign s_axi_ctrl_arready = !rvalid_q;

    assign aw_hs  = s_axi_ctrl_awvalid && s_axi_ctrl_awready;
    assign w_hs   = s_axi_ctrl_wvalid && s_axi_ctrl_wready;
    // Commit only from latched AW/W, and never while a response is pending.
    assign commit = (wr_state_q == WR_HAVE_BOTH) && !bvalid_q;

    assign rd_idx = s_axi_ctrl_araddr[ADDR_WIDTH-1:OFF_W];
    assign rd_en  = s_axi_ctrl_arvalid && s_axi_ctrl_arready;
    assign wr_ok  = ({1'b0, aw_idx_q} < NREGS);
    assign rd_ok  = ({1'b0, rd_idx} < NREGS);

    assign wr_en   = commit && wr_ok;
    assign wr_idx  = aw_idx_q;
    assign wr_data = w_data_q;
    assign wr_mask = DATA_WIDTH'(strb_to_mask(8'(w_strb_q)));

    assign s_axi_ctrl_bvalid = bvalid_q;
    assign s_axi_ctrl_bresp  = bresp_q;
    assign s_axi_ctrl_rvalid = rvalid_q;
    assign s_axi_ctrl_rdata  = rdata_q;
    assign s_axi_ctrl_rresp  = rresp_q;

    always_comb begin
        wr_state_d = wr_state_q;
        aw_idx_d   = aw_idx_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;

        if (aw_hs) begin
            aw_idx_d = s_axi_ctrl_awaddr[ADDR_WIDTH-1:OFF_W];
        end
        if (w_hs) begin
            w_data_d = s_axi_ctrl_wdata;
            w_strb_d = s_axi_ctrl_wstrb;
        end

        unique case (wr_state_q)
            WR_IDLE: begin
                if (aw_hs && w_hs) wr_state_d = WR_HAVE_BOTH;
                else if (aw_hs)    wr_state_d = WR_HAVE_AW;
                else if (w_hs)     wr_state_d = WR_HAVE_W;
            end
            WR_HAVE_AW: begin
                if (w_hs) wr_state_d = WR_HAVE_BOTH;
            end
            WR_HAVE_W: begin
                if (aw_hs) wr_state_d = WR_HAVE_BOTH;
            end
            WR_HAVE_BOTH: begin
                if (commit) wr_state_d = WR_IDLE;
            end
            default: wr_state_d = WR_IDLE;
        endcase

        if (bvalid_q && s_axi_ctrl_bready) begin
            bvalid_d = 1'b0;
        end
        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_ok ? RESP_OKAY : RESP_DECERR;
        end
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (rvalid_q && s_axi_ctrl_rready) begin
            rvalid_d = 1'b0;
        end
        if (rd_en) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_ok ? rd_data : '0;
            rresp_d  = rd_ok ? RESP_OKAY : RESP_DECERR;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_state_q <= WR_IDLE;
            aw_idx_q   <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            aw_idx_q   <= aw_idx_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

endmodule

// File: rtl/role_ctrl_regfile.sv
// AXI4-Lite control register file for the role: CTRL (soft reset, doorbell),
// W1C IRQ status, IRQ enable, general RW/RO regs. Ports: s_axi_ctrl_*, reg_out,
// ro_in, irq_set, irq, role_soft_rst, doorbell.
module role_ctrl_regfile
    import role_ctrl_pkg::*;
#(
    parameter int                ADDR_WIDTH = 20,
    parameter int                DATA_WIDTH = 32,
    parameter int                NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0,
    parameter int                IRQ_WIDTH  = 8
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic                           s_axi_ctrl_awvalid,
    output logic                           s_axi_ctrl_awready,
    input  logic [ADDR_WIDTH-1:0]          s_axi_ctrl_awaddr,
    input  logic [2:0]                     s_axi_ctrl_awprot,
    input  logic                           s_axi_ctrl_wvalid,
    output logic                           s_axi_ctrl_wready,
    input  logic [DATA_WIDTH-1:0]          s_axi_ctrl_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_axi_ctrl_wstrb,
    output logic                           s_axi_ctrl_bvalid,
    input  logic                           s_axi_ctrl_bready,
    output logic [1:0]                     s_axi_ctrl_bresp,
    input  logic                           s_axi_ctrl_arvalid,
    output logic                           s_axi_ctrl_arready,
    input  logic [ADDR_WIDTH-1:0]          s_axi_ctrl_araddr,
    input  logic [2:0]                     s_axi_ctrl_arprot,
    output logic                           s_axi_ctrl_rvalid,
    input  logic                           s_axi_ctrl_rready,
    output logic [DATA_WIDTH-1:0]          s_axi_ctrl_rdata,
    output logic [1:0]                     s_axi_ctrl_rresp,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_in,
    input  logic [IRQ_WIDTH-1:0]           irq_set,
    output logic                           irq,
    output logic                           role_soft_rst,
    output logic                           doorbell
);

    localparam int IDX_W = ADDR_WIDTH - $clog2(DATA_WIDTH / 8);
    // CTRL, IRQ_STATUS and IRQ_ENABLE are always writable.
    localparam logic [NUM_REGS-1:0] RO_EFF =
        RO_MASK & ~NUM_REGS'(3'b111);
    localparam logic [DATA_WIDTH-1:0] IRQ_MASK =
        DATA_WIDTH'((65'd1 << IRQ_WIDTH) - 65'd1);

    logic                  wr_en;
    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] wr_mask;
    logic                  rd_en;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] rd_data;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [DATA_WIDTH-1:0] view   [NUM_REGS];
    logic [DATA_WIDTH-1:0] w1c_mask;
    logic [DATA_WIDTH-1:0] irq_set_ext;
    logic                  irq_q, irq_d;
    logic                  doorbell_q, doorbell_d;

    role_ctrl_axil_if #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_axil_if (
        .aclk               (aclk),
        .areset             (areset),
        .s_axi_ctrl_awvalid (s_axi_ctrl_awvalid),
        .s_axi_ctrl_awready (s_axi_ctrl_awready),
        .s_axi_ctrl_awaddr  (s_axi_ctrl_awaddr),
        .s_axi_ctrl_awprot  (s_axi_ctrl_awprot),
        .s_axi_ctrl_wvalid  (s_axi_ctrl_wvalid),
        .s_axi_ctrl_wready  (s_axi_ctrl_wready),
        .s_axi_ctrl_wdata   (s_axi_ctrl_wdata),
        .s_axi_ctrl_wstrb   (s_axi_ctrl_wstrb),
        .s_axi_ctrl_bvalid  (s_axi_ctrl_bvalid),
        .s_axi_ctrl_bready  (s_axi_ctrl_bready),
        .s_axi_ctrl_bresp   (s_axi_ctrl_bresp),
        .s_axi_ctrl_arvalid (s_axi_ctrl_arvalid),
        .s_axi_ctrl_arready (s_axi_ctrl_arready),
        .s_axi_ctrl_araddr  (s_axi_ctrl_araddr),
        .s_axi_ctrl_arprot  (s_axi_ctrl_arprot),
        .s_axi_ctrl_rvalid  (s_axi_ctrl_rvalid),
        .s_axi_ctrl_rready  (s_axi_ctrl_rready),
        .s_axi_ctrl_rdata   (s_axi_ctrl_rdata),
        .s_axi_ctrl_rresp   (s_axi_ctrl_rresp),
        .wr_en              (wr_en),
        .wr_idx             (wr_idx),
        .wr_data            (wr_data),
        .wr_mask            (wr_mask),
        .rd_en              (rd_en),
        .rd_idx             (rd_idx),
        .rd_data            (rd_data)
    );

    assign irq_set_ext   = DATA_WIDTH'(irq_set);
    assign irq           = irq_q;
    assign doorbell      = doorbell_q;
    assign role_soft_rst = regs_q[REG_CTRL][CTRL_SOFT_RST_BIT];

    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            view[i] = RO_EFF[i] ? ro_in[i*DATA_WIDTH +: DATA_WIDTH]
                                : regs_q[i];
            reg_out[i*DATA_WIDTH +: DATA_WIDTH] = view[i];
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_en) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (rd_idx == IDX_W'(i)) rd_data = view[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_en && (wr_idx == IDX_W'(i)) && !RO_EFF[i] &&
                (i != REG_IRQ_STATUS)) begin
                regs_d[i] = (regs_q[i] & ~wr_mask) | (wr_data & wr_mask);
            end
        end
        // Doorbell is a pulse, never stored.
        regs_d[REG_CTRL][CTRL_DOORBELL_BIT] = 1'b0;

        w1c_mask = '0;
        if (wr_en && (wr_idx == IDX_W'(REG_IRQ_STATUS))) begin
            w1c_mask = wr_data & wr_mask;
        end
        // Set after clear so a same-cycle set survives the W1C.
        regs_d[REG_IRQ_STATUS] =
            ((regs_q[REG_IRQ_STATUS] & ~w1c_mask) | irq_set_ext) & IRQ_MASK;

        doorbell_d = wr_en && (wr_idx == IDX_W'(REG_CTRL)) &&
                     wr_mask[CTRL_DOORBELL_BIT] && wr_data[CTRL_DOORBELL_BIT];
        irq_d = |(regs_q[REG_IRQ_STATUS] & regs_q[REG_IRQ_ENABLE] & IRQ_MASK);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            irq_q      <= 1'b0;
            doorbell_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            irq_q      <= irq_d;
            doorbell_q <= doorbell_d;
        end
    end

endmodule
